// File: rtl/data_mem_if.sv
// CPU load/store bus between the MIPS core (master) and the data-memory block (slave).
interface data_mem_if;
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        read_acc;
    logic        write_acc;

    modport master (
        output read, write, addr, wdata,
        input  rdata, read_acc, write_acc
    );

    modport slave (
        input  read, write, addr, wdata,
        output rdata, read_acc, write_acc
    );
endinterface

// File: rtl/data_mem.sv
// Data RAM plus memory-mapped timer, LED, switch, 7-seg and UART registers for the MIPS core.
// Optional macro UART_IRQ_EN adds UCON[1:0] and the UART interrupt terms.
module data_mem #(
    parameter int unsigned RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    data_mem_if.slave   bus,
    output logic [7:0]  led,
    input  logic [7:0]  switch,
    output logic [11:0] digits,
    output logic [7:0]  UART_TXD,
    input  logic [7:0]  UART_RXD,
    input  logic        TX_STATUS,
    input  logic        RX_EFF,
    output logic        TX_EN,
    output logic        RX_READ,
    output logic        interrupt
);
    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    logic [31:0] ram_q [RAM_WORDS];
    logic [31:0] th_q, th_d, tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d, txd_q, txd_d;
    logic [11:0] dig_q, dig_d;
    logic        tx_en_q, tx_en_d;
    logic [1:0]  ucon;

    logic [31:0] wa;
    logic [AW-1:0] ram_idx;
    logic ram_hit, sel_th, sel_tl, sel_tcon, sel_led, sel_sw, sel_dig, sel_txd, sel_rxd, sel_ucon;
    logic reg_hit, ro_hit, txd_blocked;

    assign wa       = {bus.addr[31:2], 2'b00};
    assign ram_idx  = bus.addr[AW+1:2];
    assign ram_hit  = bus.addr < RAM_BYTES;
    assign sel_th   = wa == 32'h4000_0000;
    assign sel_tl   = wa == 32'h4000_0004;
    assign sel_tcon = wa == 32'h4000_0008;
    assign sel_led  = wa == 32'h4000_000C;
    assign sel_sw   = wa == 32'h4000_0010;
    assign sel_dig  = wa == 32'h4000_0014;
    assign sel_txd  = wa == 32'h4000_0018;
    assign sel_rxd  = wa == 32'h4000_001C;
    assign sel_ucon = wa == 32'h4000_0020;
    assign reg_hit  = sel_th | sel_tl | sel_tcon | sel_led | sel_sw | sel_dig | sel_txd |
                      sel_rxd | sel_ucon;
    assign ro_hit      = sel_sw | sel_rxd;
    assign txd_blocked = sel_txd & ~TX_STATUS;

    assign bus.read_acc  = bus.read & (ram_hit | reg_hit);
    assign bus.write_acc = bus.write & (ram_hit | (reg_hit & ~ro_hit)) & ~txd_blocked;
    assign RX_READ       = bus.read & sel_rxd;

    always_comb begin
        bus.rdata = 32'd0;
        if (bus.read) begin
            if (ram_hit)       bus.rdata = ram_q[ram_idx];
            else if (sel_th)   bus.rdata = th_q;
            else if (sel_tl)   bus.rdata = tl_q;
            else if (sel_tcon) bus.rdata = {29'd0, tcon_q};
            else if (sel_led)  bus.rdata = {24'd0, led_q};
            else if (sel_sw)   bus.rdata = {24'd0, switch};
            else if (sel_dig)  bus.rdata = {20'd0, dig_q};
            else if (sel_txd)  bus.rdata = {24'd0, txd_q};
            else if (sel_rxd)  bus.rdata = {24'd0, UART_RXD};
            else if (sel_ucon) bus.rdata = {28'd0, ~TX_STATUS, RX_EFF, ucon};
        end
    end

    always_comb begin
        th_d    = th_q;
        tl_d    = tl_q;
        tcon_d  = tcon_q;
        led_d   = led_q;
        dig_d   = dig_q;
        txd_d   = txd_q;
        tx_en_d = 1'b0;
        if (tcon_q[0]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[1]) tcon_d[2] = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        // CPU stores are applied after the count so they win on a collision.
        if (bus.write) begin
            if (sel_th)   th_d   = bus.wdata;
            if (sel_tl)   tl_d   = bus.wdata;
            if (sel_tcon) tcon_d = bus.wdata[2:0];
            if (sel_led)  led_d  = bus.wdata[7:0];
            if (sel_dig)  dig_d  = bus.wdata[11:0];
            if (sel_txd && TX_STATUS) begin
                txd_d   = bus.wdata[7:0];
                tx_en_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q    <= 32'd0;
            tl_q    <= 32'd0;
            tcon_q  <= 3'd0;
            led_q   <= 8'd0;
            dig_q   <= 12'd0;
            txd_q   <= 8'd0;
            tx_en_q <= 1'b0;
        end else begin
            th_q    <= th_d;
            tl_q    <= tl_d;
            tcon_q  <= tcon_d;
            led_q   <= led_d;
            dig_q   <= dig_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && bus.write && ram_hit) ram_q[ram_idx] <= bus.wdata;
    end

`ifdef UART_IRQ_EN
    logic [1:0] ucon_q, ucon_d;

    always_comb begin
        ucon_d = ucon_q;
        if (bus.write && sel_ucon) ucon_d = bus.wdata[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) ucon_q <= 2'd0;
        else       ucon_q <= ucon_d;
    end

    assign ucon      = ucon_q;
    assign interrupt = tcon_q[2] | (ucon_q[0] & RX_EFF) | (ucon_q[1] & TX_STATUS);
`else
    assign ucon      = 2'd0;
    assign interrupt = tcon_q[2];
`endif

    assign led      = led_q;
    assign digits   = dig_q;
    assign UART_TXD = txd_q;
    assign TX_EN    = tx_en_q;
endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: expectations are queued as stimulus is driven, checked at negedge.
module tb_data_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  led, switch, UART_TXD, UART_RXD;
    logic [11:0] digits;
    logic        TX_STATUS, RX_EFF, TX_EN, RX_READ, interrupt;

    data_mem_if bus ();

    data_mem #(.RAM_WORDS(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .led       (led),
        .switch    (switch),
        .digits    (digits),
        .UART_TXD  (UART_TXD),
        .UART_RXD  (UART_RXD),
        .TX_STATUS (TX_STATUS),
        .RX_EFF    (RX_EFF),
        .TX_EN     (TX_EN),
        .RX_READ   (RX_READ),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

`ifdef UART_IRQ_EN
    localparam bit Feat = 1'b1;
`else
    localparam bit Feat = 1'b0;
`endif

    typedef enum int {SelRdata, SelRacc, SelWacc, SelLed, SelDig, SelTxd, SelTxEn, SelRxRd,
                      SelIrq} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int    errors = 0;
    int    checks = 0;

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            SelRdata: return bus.rdata;
            SelRacc:  return {31'd0, bus.read_acc};
            SelWacc:  return {31'd0, bus.write_acc};
            SelLed:   return {24'd0, led};
            SelDig:   return {20'd0, digits};
            SelTxd:   return {24'd0, UART_TXD};
            SelTxEn:  return {31'd0, TX_EN};
            SelRxRd:  return {31'd0, RX_READ};
            default:  return {31'd0, interrupt};
        endcase
    endfunction

    task automatic expect_q(input string tag, input sel_e s, input logic [31:0] v);
        item_t it;
        it.tag = tag;
        it.sel = s;
        it.exp = v;
        sb.push_back(it);
    endtask

    task automatic sample();
        item_t       it;
        logic [31:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = observe(it.sel);
            checks++;
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic acc);
        bus.write = 1'b1;
        bus.read  = 1'b0;
        bus.addr  = a;
        bus.wdata = d;
        expect_q({tag, "_wacc"}, SelWacc, {31'd0, acc});
        sample();
        tick();
        idle();
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic acc);
        bus.read  = 1'b1;
        bus.write = 1'b0;
        bus.addr  = a;
        expect_q({tag, "_rdata"}, SelRdata, d);
        expect_q({tag, "_racc"}, SelRacc, {31'd0, acc});
        sample();
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        switch    = 8'd0;
        UART_RXD  = 8'd0;
        TX_STATUS = 1'b1;
        RX_EFF    = 1'b0;
        idle();
        tick();
        tick();
        expect_q("rst_led", SelLed, 32'd0);
        expect_q("rst_dig", SelDig, 32'd0);
        expect_q("rst_txd", SelTxd, 32'd0);
        expect_q("rst_irq", SelIrq, 32'd0);
        expect_q("rst_txen", SelTxEn, 32'd0);
        sample();
        reset = 1'b0;
        tick();

        // LED / digits registers, including width masking of wdata
        wr("led", 32'h4000_000C, 32'h0000_003C, 1'b1);
        expect_q("led_out", SelLed, 32'h3C);
        wr("dig", 32'h4000_0014, 32'hFFFF_FABC, 1'b1);
        expect_q("dig_out", SelDig, 32'hABC);
        rd("led_rd", 32'h4000_000C, 32'h3C, 1'b1);
        rd("dig_rd", 32'h4000_0014, 32'hABC, 1'b1);

        // TX: accepted write pulses TX_EN one cycle later; blocked while busy
        expect_q("tx_en_pre", SelTxEn, 32'd0);
        wr("txd", 32'h4000_0018, 32'h0000_00CC, 1'b1);
        expect_q("txd_out", SelTxd, 32'hCC);
        expect_q("tx_en_pulse", SelTxEn, 32'd1);
        sample();
        tick();
        expect_q("tx_en_drop", SelTxEn, 32'd0);
        sample();
        TX_STATUS = 1'b0;
        wr("txd_busy", 32'h4000_0018, 32'h0000_0011, 1'b0);
        expect_q("txd_hold", SelTxd, 32'hCC);
        expect_q("tx_en_busy", SelTxEn, 32'd0);
        sample();
        TX_STATUS = 1'b1;
        tick();

        // RAM, boundary and unmapped addresses
        wr("ram0", 32'h0000_0000, 32'h0000_00CC, 1'b1);
        wr("ram_top", 32'h0000_03FC, 32'hDEAD_BEEF, 1'b1);
        wr("ram_past", 32'h0000_0400, 32'h1234_5678, 1'b0);
        rd("ram0_rd", 32'h0000_0000, 32'h0000_00CC, 1'b1);
        rd("ram0_lsb", 32'h0000_0002, 32'h0000_00CC, 1'b1);
        rd("ram_top_rd", 32'h0000_03FC, 32'hDEAD_BEEF, 1'b1);
        rd("ram_past_rd", 32'h0000_0400, 32'd0, 1'b0);
        rd("unmapped", 32'h2000_0000, 32'd0, 1'b0);
        bus.addr = 32'h0000_0000;
        expect_q("noread_rdata", SelRdata, 32'd0);
        expect_q("noread_racc", SelRacc, 32'd0);
        sample();
        tick();

        // UCON and UART interrupt terms
        RX_EFF = 1'b1;
        wr("ucon1", 32'h4000_0020, 32'h1, 1'b1);
        expect_q("ucon1_irq", SelIrq, {31'd0, Feat});
        rd("ucon1_rd", 32'h4000_0020, Feat ? 32'h5 : 32'h4, 1'b1);
        wr("ucon0", 32'h4000_0020, 32'h0, 1'b1);
        expect_q("ucon0_irq", SelIrq, 32'd0);
        rd("ucon0_rd", 32'h4000_0020, 32'h4, 1'b1);
        RX_EFF    = 1'b0;
        TX_STATUS = 1'b0;
        rd("ucon_busy", 32'h4000_0020, 32'h8, 1'b1);
        TX_STATUS = 1'b1;

        // Timer overflow reload, irq, clear, store-over-count priority, stop
        wr("th", 32'h4000_0000, 32'd5, 1'b1);
        wr("tl", 32'h4000_0004, 32'hFFFF_FFFE, 1'b1);
        wr("tcon", 32'h4000_0008, 32'd3, 1'b1);
        expect_q("tmr_noirq", SelIrq, 32'd0);
        sample();
        tick();
        tick();
        expect_q("tmr_irq", SelIrq, 32'd1);
        rd("tmr_reload", 32'h4000_0004, 32'd5, 1'b1);
        rd("tcon_rd", 32'h4000_0008, 32'd7, 1'b1);
        rd("th_rd", 32'h4000_0000, 32'd5, 1'b1);
        wr("tcon_clr", 32'h4000_0008, 32'd3, 1'b1);
        expect_q("tmr_irq_clr", SelIrq, 32'd0);
        wr("tl_prio", 32'h4000_0004, 32'd100, 1'b1);
        rd("tl_prio_rd", 32'h4000_0004, 32'd100, 1'b1);
        wr("tcon_off", 32'h4000_0008, 32'd0, 1'b1);
        rd("tl_stop1", 32'h4000_0004, 32'd102, 1'b1);
        tick();
        rd("tl_stop2", 32'h4000_0004, 32'd102, 1'b1);

        // RX and switches
        UART_RXD = 8'h5A;
        switch   = 8'hA5;
        expect_q("rx_read", SelRxRd, 32'd1);
        rd("rxd_rd", 32'h4000_001C, 32'h5A, 1'b1);
        expect_q("rx_read_other", SelRxRd, 32'd0);
        rd("sw_rd", 32'h4000_0010, 32'hA5, 1'b1);
        wr("rxd_ro", 32'h4000_001C, 32'hFF, 1'b0);
        wr("sw_ro", 32'h4000_0010, 32'hFF, 1'b0);

        // Status bit written directly raises irq; reset during a store clears everything
        wr("tcon_set", 32'h4000_0008, 32'd4, 1'b1);
        expect_q("irq_forced", SelIrq, 32'd1);
        sample();
        reset     = 1'b1;
        bus.write = 1'b1;
        bus.addr  = 32'h4000_000C;
        bus.wdata = 32'hFF;
        tick();
        expect_q("mid_rst_led", SelLed, 32'd0);
        expect_q("mid_rst_dig", SelDig, 32'd0);
        expect_q("mid_rst_txd", SelTxd, 32'd0);
        expect_q("mid_rst_irq", SelIrq, 32'd0);
        sample();
        reset = 1'b0;
        idle();
        tick();
        rd("rst_th", 32'h4000_0000, 32'd0, 1'b1);
        rd("ram_kept", 32'h0000_0000, 32'h0000_00CC, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
